// File: rtl/sirv_debug_entry_ctrl_pkg.sv
// Shared cause codes, state encoding and defaults for the commit-stage debug entry controller.
package sirv_debug_entry_ctrl_pkg;

  localparam logic [2:0] DCAUSE_NONE   = 3'd0;
  localparam logic [2:0] DCAUSE_EBREAK = 3'd1;
  localparam logic [2:0] DCAUSE_IRQ    = 3'd3;
  localparam logic [2:0] DCAUSE_STEP   = 3'd4;
  localparam logic [2:0] DCAUSE_HALT   = 3'd5;

  localparam logic [31:0] DEBUG_ROM_ADDR_DEFAULT = 32'h0000_0800;

  typedef enum logic [2:0] {
    StRun       = 3'd0,
    StStep      = 3'd1,
    StEnterWait = 3'd2,
    StDebug     = 3'd3,
    StExitWait  = 3'd4
  } dbg_state_e;

  typedef enum logic {
    DpcSelPc    = 1'b0,
    DpcSelPcNxt = 1'b1
  } dpc_sel_e;

endpackage

// File: rtl/sirv_debug_cause_sel.sv
// Priority encoder for debug entry from RUN/STEP: ebreak > irq > halt > completed single step.
module sirv_debug_cause_sel
  import sirv_debug_entry_ctrl_pkg::*;
(
  input  logic       valid,
  input  logic       in_step,
  input  logic       ebreak,
  input  logic       ebreakm,
  input  logic       irq,
  input  logic       halt,
  input  logic       dret,
  output logic       take,
  output logic [2:0] cause,
  output dpc_sel_e   dpc_sel
);

  always_comb begin
    take    = 1'b0;
    cause   = DCAUSE_NONE;
    dpc_sel = DpcSelPc;
    if (valid) begin
      if (ebreak && ebreakm) begin
        take  = 1'b1;
        cause = DCAUSE_EBREAK;
      end else if (irq) begin
        take  = 1'b1;
        cause = DCAUSE_IRQ;
      end else if (halt) begin
        take  = 1'b1;
        cause = DCAUSE_HALT;
      end else if (in_step && !dret) begin
        // The stepped instruction retires; debug resumes at the instruction after it.
        take    = 1'b1;
        cause   = DCAUSE_STEP;
        dpc_sel = DpcSelPcNxt;
      end
    end
  end

endmodule

// File: rtl/sirv_debug_entry_ctrl.sv
// Commit-stage debug entry/exit controller: DPC/DCAUSE strobes, held flush/redirect, single-step.
module sirv_debug_entry_ctrl
  import sirv_debug_entry_ctrl_pkg::*;
#(
  parameter int unsigned PC_SIZE        = 32,
  parameter logic [31:0] DEBUG_ROM_ADDR = DEBUG_ROM_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmt_i_valid,
  input  logic [PC_SIZE-1:0] cmt_i_pc,
  input  logic [PC_SIZE-1:0] cmt_i_pc_nxt,
  input  logic               cmt_i_ebreak,
  input  logic               cmt_i_dret,
  output logic               cmt_i_retire,
  output logic               dret_illegal,
  input  logic               dbg_halt_r,
  input  logic               dbg_step_r,
  input  logic               dbg_ebreakm_r,
  input  logic               dbg_irq_r,
  input  logic [PC_SIZE-1:0] dpc_r,
  output logic [PC_SIZE-1:0] cmt_dpc,
  output logic               cmt_dpc_ena,
  output logic [2:0]         cmt_dcause,
  output logic               cmt_dcause_ena,
  output logic               dbg_flush_req,
  output logic [PC_SIZE-1:0] dbg_flush_pc,
  input  logic               dbg_flush_ack,
  output logic               dbg_mode_o
);

  localparam logic [PC_SIZE-1:0] RomPc       = DEBUG_ROM_ADDR[PC_SIZE-1:0];
  localparam logic [PC_SIZE-1:0] PcAlignMask = {{(PC_SIZE-1){1'b1}}, 1'b0};

  dbg_state_e         state_q, state_d;
  logic               req_q, req_d;
  logic [PC_SIZE-1:0] flush_pc_q, flush_pc_d;
  logic               step_q, step_d;

  logic               in_run_step;
  logic               sel_take;
  logic [2:0]         sel_cause;
  dpc_sel_e           sel_dpc;

  assign in_run_step = (state_q == StRun) || (state_q == StStep);

  sirv_debug_cause_sel u_cause_sel (
    .valid   (cmt_i_valid && in_run_step),
    .in_step (state_q == StStep),
    .ebreak  (cmt_i_ebreak),
    .ebreakm (dbg_ebreakm_r),
    .irq     (dbg_irq_r),
    .halt    (dbg_halt_r),
    .dret    (cmt_i_dret),
    .take    (sel_take),
    .cause   (sel_cause),
    .dpc_sel (sel_dpc)
  );

  always_comb begin
    state_d        = state_q;
    flush_pc_d     = flush_pc_q;
    step_d         = step_q;
    cmt_i_retire   = 1'b0;
    dret_illegal   = 1'b0;
    cmt_dpc        = '0;
    cmt_dpc_ena    = 1'b0;
    cmt_dcause     = DCAUSE_NONE;
    cmt_dcause_ena = 1'b0;

    unique case (state_q)
      StRun, StStep: begin
        if (cmt_i_valid) begin
          if (sel_take) begin
            cmt_dpc_ena    = 1'b1;
            cmt_dcause_ena = 1'b1;
            cmt_dcause     = sel_cause;
            cmt_dpc        = ((sel_dpc == DpcSelPcNxt) ? cmt_i_pc_nxt : cmt_i_pc) & PcAlignMask;
            cmt_i_retire   = (sel_dpc == DpcSelPcNxt);
            flush_pc_d     = RomPc;
            state_d        = StEnterWait;
          end else if (cmt_i_dret) begin
            dret_illegal = 1'b1;
          end else begin
            cmt_i_retire = 1'b1;
          end
        end
      end
      StDebug: begin
        if (cmt_i_valid) begin
          if (cmt_i_ebreak) begin
            flush_pc_d = RomPc;
            state_d    = StEnterWait;
          end else if (cmt_i_dret) begin
            cmt_i_retire   = 1'b1;
            cmt_dcause_ena = 1'b1;
            flush_pc_d     = dpc_r;
            step_d         = dbg_step_r;
            state_d        = StExitWait;
          end else begin
            cmt_i_retire = 1'b1;
          end
        end
      end
      StEnterWait: begin
        if (dbg_flush_ack) state_d = StDebug;
      end
      StExitWait: begin
        if (dbg_flush_ack) state_d = step_q ? StStep : StRun;
      end
      default: state_d = StRun;
    endcase

    // No commit-side strobes while reset is held.
    if (!rst_n) begin
      cmt_i_retire   = 1'b0;
      dret_illegal   = 1'b0;
      cmt_dpc        = '0;
      cmt_dpc_ena    = 1'b0;
      cmt_dcause     = DCAUSE_NONE;
      cmt_dcause_ena = 1'b0;
    end
  end

  assign req_d = (state_d == StEnterWait) || (state_d == StExitWait);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StRun;
      req_q      <= 1'b0;
      flush_pc_q <= '0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      flush_pc_q <= flush_pc_d;
      step_q     <= step_d;
    end
  end

  assign dbg_flush_req = req_q;
  assign dbg_flush_pc  = flush_pc_q;
  assign dbg_mode_o    = (state_q == StDebug) || (state_q == StEnterWait);

endmodule

// File: tb/tb_sirv_debug_entry_ctrl.sv
// Directed and randomized bench for sirv_debug_entry_ctrl against a behavioural mode model.
module tb_sirv_debug_entry_ctrl;

  localparam logic [31:0] ROM = 32'h0000_0800;

  logic        clk;
  logic        rst_n;
  logic        cmt_i_valid;
  logic [31:0] cmt_i_pc;
  logic [31:0] cmt_i_pc_nxt;
  logic        cmt_i_ebreak;
  logic        cmt_i_dret;
  logic        cmt_i_retire;
  logic        dret_illegal;
  logic        dbg_halt_r;
  logic        dbg_step_r;
  logic        dbg_ebreakm_r;
  logic        dbg_irq_r;
  logic [31:0] dpc_r;
  logic [31:0] cmt_dpc;
  logic        cmt_dpc_ena;
  logic [2:0]  cmt_dcause;
  logic        cmt_dcause_ena;
  logic        dbg_flush_req;
  logic [31:0] dbg_flush_pc;
  logic        dbg_flush_ack;
  logic        dbg_mode_o;

  sirv_debug_entry_ctrl u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmt_i_valid    (cmt_i_valid),
    .cmt_i_pc       (cmt_i_pc),
    .cmt_i_pc_nxt   (cmt_i_pc_nxt),
    .cmt_i_ebreak   (cmt_i_ebreak),
    .cmt_i_dret     (cmt_i_dret),
    .cmt_i_retire   (cmt_i_retire),
    .dret_illegal   (dret_illegal),
    .dbg_halt_r     (dbg_halt_r),
    .dbg_step_r     (dbg_step_r),
    .dbg_ebreakm_r  (dbg_ebreakm_r),
    .dbg_irq_r      (dbg_irq_r),
    .dpc_r          (dpc_r),
    .cmt_dpc        (cmt_dpc),
    .cmt_dpc_ena    (cmt_dpc_ena),
    .cmt_dcause     (cmt_dcause),
    .cmt_dcause_ena (cmt_dcause_ena),
    .dbg_flush_req  (dbg_flush_req),
    .dbg_flush_pc   (dbg_flush_pc),
    .dbg_flush_ack  (dbg_flush_ack),
    .dbg_mode_o     (dbg_mode_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: debug-mode flag (DEBUG or entering), pending-flush flag and target, stepping flag.
  bit          m_dbg, m_wait, m_step, m_ret_step;
  logic [31:0] m_fpc;
  bit          n_dbg, n_wait, n_step, n_ret_step;
  logic [31:0] n_fpc;

  task automatic eval_cycle();
    bit          e_retire, e_illegal, e_dpc_ena, e_dcause_ena;
    logic [31:0] e_dpc;
    logic [2:0]  e_dcause;
    logic [2:0]  cause;
    @(negedge clk);
    e_retire = 0; e_illegal = 0; e_dpc_ena = 0; e_dcause_ena = 0; e_dpc = '0; e_dcause = '0;
    n_dbg = m_dbg; n_wait = m_wait; n_step = m_step; n_ret_step = m_ret_step; n_fpc = m_fpc;
    if (!rst_n) begin
      n_dbg = 0; n_wait = 0; n_step = 0; n_ret_step = 0; n_fpc = '0;
    end else if (m_wait) begin
      if (dbg_flush_ack) begin
        n_wait = 0;
        if (!m_dbg) n_step = m_ret_step;
      end
    end else if (m_dbg) begin
      if (cmt_i_valid) begin
        if (cmt_i_ebreak) begin
          n_wait = 1; n_fpc = ROM;
        end else if (cmt_i_dret) begin
          e_retire = 1; e_dcause_ena = 1;
          n_dbg = 0; n_wait = 1; n_fpc = dpc_r; n_ret_step = dbg_step_r;
        end else begin
          e_retire = 1;
        end
      end
    end else if (cmt_i_valid) begin
      cause = 3'd0;
      if (cmt_i_ebreak && dbg_ebreakm_r) cause = 3'd1;
      else if (dbg_irq_r)                cause = 3'd3;
      else if (dbg_halt_r)               cause = 3'd5;
      if (cause != 0) begin
        e_dpc = cmt_i_pc & 32'hFFFF_FFFE;
      end else if (cmt_i_dret) begin
        e_illegal = 1;
      end else begin
        e_retire = 1;
        if (m_step) begin
          cause = 3'd4;
          e_dpc = cmt_i_pc_nxt & 32'hFFFF_FFFE;
        end
      end
      if (cause != 0) begin
        e_dpc_ena = 1; e_dcause_ena = 1; e_dcause = cause;
        n_dbg = 1; n_wait = 1; n_fpc = ROM; n_step = 0;
      end
    end
    check_eq("retire",       32'(cmt_i_retire),   32'(e_retire));
    check_eq("dret_illegal", 32'(dret_illegal),   32'(e_illegal));
    check_eq("dpc_ena",      32'(cmt_dpc_ena),    32'(e_dpc_ena));
    check_eq("dpc",          cmt_dpc,             e_dpc);
    check_eq("dcause_ena",   32'(cmt_dcause_ena), 32'(e_dcause_ena));
    check_eq("dcause",       32'(cmt_dcause),     32'(e_dcause));
    check_eq("flush_req",    32'(dbg_flush_req),  32'(m_wait));
    check_eq("flush_pc",     dbg_flush_pc,        m_fpc);
    check_eq("dbg_mode",     32'(dbg_mode_o),     32'(m_dbg));
  endtask

  task automatic advance();
    @(posedge clk);
    m_dbg = n_dbg; m_wait = n_wait; m_step = n_step; m_ret_step = n_ret_step; m_fpc = n_fpc;
    #1;
  endtask

  task automatic cyc();
    eval_cycle();
    advance();
  endtask

  task automatic idle();
    cmt_i_valid = 0; cmt_i_ebreak = 0; cmt_i_dret = 0;
    dbg_irq_r = 0; dbg_halt_r = 0; dbg_flush_ack = 0;
  endtask

  initial begin
    m_dbg = 0; m_wait = 0; m_step = 0; m_ret_step = 0; m_fpc = '0;
    rst_n = 0; idle();
    cmt_i_pc = '0; cmt_i_pc_nxt = '0; dpc_r = '0; dbg_step_r = 0; dbg_ebreakm_r = 0;
    @(posedge clk); #1;
    cyc(); cyc();
    rst_n = 1;

    // ebreak entry from RUN
    dbg_ebreakm_r = 1; cmt_i_valid = 1; cmt_i_ebreak = 1;
    cmt_i_pc = 32'h100; cmt_i_pc_nxt = 32'h104;
    eval_cycle();
    check_eq("t_ebk_dpc_ena", 32'(cmt_dpc_ena), 1);
    check_eq("t_ebk_dpc", cmt_dpc, 32'h100);
    check_eq("t_ebk_cause", 32'(cmt_dcause), 1);
    check_eq("t_ebk_retire", 32'(cmt_i_retire), 0);
    advance();
    idle(); eval_cycle();
    check_eq("t_ebk_req", 32'(dbg_flush_req), 1);
    check_eq("t_ebk_fpc", dbg_flush_pc, ROM);
    advance();
    dbg_flush_ack = 1; cyc(); idle();
    eval_cycle(); check_eq("t_ebk_mode", 32'(dbg_mode_o), 1); advance();

    // dret with step armed, then the stepped instruction
    dpc_r = 32'h344; dbg_step_r = 1; cmt_i_valid = 1; cmt_i_dret = 1; cmt_i_pc = 32'h3000;
    eval_cycle();
    check_eq("t_dret_cause_ena", 32'(cmt_dcause_ena), 1);
    check_eq("t_dret_cause", 32'(cmt_dcause), 0);
    check_eq("t_dret_retire", 32'(cmt_i_retire), 1);
    advance();
    idle(); eval_cycle(); check_eq("t_dret_fpc", dbg_flush_pc, 32'h344); advance();
    dbg_flush_ack = 1; cyc(); idle();
    cmt_i_valid = 1; cmt_i_pc = 32'h344; cmt_i_pc_nxt = 32'h348; dbg_step_r = 0;
    eval_cycle();
    check_eq("t_step_retire", 32'(cmt_i_retire), 1);
    check_eq("t_step_dpc", cmt_dpc, 32'h348);
    check_eq("t_step_cause", 32'(cmt_dcause), 4);
    advance();

    // ack held low for 5 cycles with a slot presented
    idle(); cmt_i_valid = 1; cmt_i_pc = 32'h500;
    repeat (5) begin
      eval_cycle();
      check_eq("t_hold_req", 32'(dbg_flush_req), 1);
      check_eq("t_hold_fpc", dbg_flush_pc, ROM);
      check_eq("t_hold_retire", 32'(cmt_i_retire), 0);
      advance();
    end
    idle(); dbg_flush_ack = 1; cyc(); idle();
    eval_cycle(); check_eq("t_ack_drop", 32'(dbg_flush_req), 0); advance();

    // ebreak while in DEBUG re-enters the ROM without CSR updates
    cmt_i_valid = 1; cmt_i_ebreak = 1;
    eval_cycle();
    check_eq("t_debk_dpc_ena", 32'(cmt_dpc_ena), 0);
    check_eq("t_debk_cause_ena", 32'(cmt_dcause_ena), 0);
    check_eq("t_debk_retire", 32'(cmt_i_retire), 0);
    advance();
    idle(); eval_cycle(); check_eq("t_debk_fpc", dbg_flush_pc, ROM); advance();
    dbg_flush_ack = 1; cyc(); idle();
    cmt_i_valid = 1; cmt_i_dret = 1; cyc(); idle();
    dbg_flush_ack = 1; cyc(); idle();

    // dret outside debug mode
    cmt_i_valid = 1; cmt_i_dret = 1;
    eval_cycle();
    check_eq("t_ill_pulse", 32'(dret_illegal), 1);
    check_eq("t_ill_retire", 32'(cmt_i_retire), 0);
    check_eq("t_ill_cause_ena", 32'(cmt_dcause_ena), 0);
    advance(); idle();

    // ebreak beats irq; then irq alone
    cmt_i_valid = 1; cmt_i_ebreak = 1; dbg_irq_r = 1; cmt_i_pc = 32'h200;
    eval_cycle(); check_eq("t_prio_cause", 32'(cmt_dcause), 1); advance(); idle();
    dbg_flush_ack = 1; cyc(); idle();
    cmt_i_valid = 1; cmt_i_dret = 1; cyc(); idle();
    dbg_flush_ack = 1; cyc(); idle();
    cmt_i_valid = 1; dbg_irq_r = 1; cmt_i_pc = 32'h200;
    eval_cycle();
    check_eq("t_irq_cause", 32'(cmt_dcause), 3);
    check_eq("t_irq_dpc", cmt_dpc, 32'h200);
    advance(); idle();

    // reset during ENTER_WAIT
    rst_n = 0; cyc(); rst_n = 1;
    eval_cycle();
    check_eq("t_rst_req", 32'(dbg_flush_req), 0);
    check_eq("t_rst_mode", 32'(dbg_mode_o), 0);
    check_eq("t_rst_fpc", dbg_flush_pc, 0);
    advance();
    cmt_i_valid = 1; cmt_i_pc = 32'h600;
    eval_cycle(); check_eq("t_rst_retire", 32'(cmt_i_retire), 1); advance(); idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned kind;
      rst_n         = ($urandom_range(0, 149) != 0);
      cmt_i_valid   = ($urandom_range(0, 9) < 7);
      kind          = $urandom_range(0, 9);
      cmt_i_ebreak  = (kind < 2);
      cmt_i_dret    = (kind == 2 || kind == 3);
      dbg_irq_r     = ($urandom_range(0, 19) == 0);
      dbg_halt_r    = ($urandom_range(0, 19) == 0);
      dbg_ebreakm_r = $urandom_range(0, 1) == 1;
      dbg_step_r    = ($urandom_range(0, 2) == 0);
      dbg_flush_ack = ($urandom_range(0, 2) == 0);
      cmt_i_pc      = $urandom;
      cmt_i_pc_nxt  = ($urandom_range(0, 1) == 1) ? cmt_i_pc + 32'd4 : $urandom;
      dpc_r         = $urandom;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
